// File: rtl/buzzer_sequencer_pkg.sv
// buzzer_sequencer_pkg: FSM encodings, default pattern timing and sizing helpers for the buzzer sequencer.
package buzzer_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  typedef enum logic {
    P_ANS = 1'b0,
    P_TO  = 1'b1
  } pat_t;

  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_ANS_BEEPS = 1;
  localparam int DEF_ANS_ON_MS = 300;
  localparam int DEF_TO_BEEPS  = 3;
  localparam int DEF_TO_ON_MS  = 200;
  localparam int DEF_OFF_MS    = 100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction

  function automatic int ms_width(input int max_ms);
    return $clog2(max_ms + 1);
  endfunction

endpackage

// File: rtl/buzzer_ms_tick.sv
// buzzer_ms_tick: millisecond prescaler emitting a one-cycle tick every TICK_DIV clocks, restartable by clr.
module buzzer_ms_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = cnt == W'(TICK_DIV - 1);

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= (clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: latches answer/time-over requests, arbitrates (time-over first) and plays
// each as N timed beeps on mutually exclusive tone-select lines.
module buzzer_sequencer
  import buzzer_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ANS_BEEPS = DEF_ANS_BEEPS,
  parameter int ANS_ON_MS = DEF_ANS_ON_MS,
  parameter int TO_BEEPS  = DEF_TO_BEEPS,
  parameter int TO_ON_MS  = DEF_TO_ON_MS,
  parameter int OFF_MS    = DEF_OFF_MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic Req_Answer,
  input  logic Req_TimeOver,
  input  logic Clear,
  output logic Tone_Answer,
  output logic Tone_TimeOver,
  output logic Busy,
  output logic Done
);

  localparam int MW = ms_width(max3(ANS_ON_MS, TO_ON_MS, OFF_MS));

  state_t        state, state_n;
  pat_t          pat, pat_n;
  logic          pend_a, pend_t, pend_a_n, pend_t_n;
  logic          load_a, load_t, enter, tick, ms_end;
  logic          done_evt, done_n;
  logic          tone_a_n, tone_t_n, busy_n, done_o_n;
  logic [MW-1:0] ms_cnt, ms_lim;
  logic [3:0]    beeps, beeps_n;

  buzzer_ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (CLK),
    .rst (RST),
    .clr (enter),
    .tick(tick)
  );

  assign ms_lim = state == S_ON ? (pat == P_TO ? MW'(TO_ON_MS - 1) : MW'(ANS_ON_MS - 1))
                                : MW'(OFF_MS - 1);
  assign ms_end = tick && ms_cnt == ms_lim;
  // a pending time-over may cut into an answer already playing
  assign load_t = pend_t && (state == S_IDLE || pat == P_ANS);
  assign load_a = pend_a && !pend_t && state == S_IDLE;
  assign enter  = Clear || load_t || state_n != state;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state         <= S_IDLE;
      pat           <= P_ANS;
      pend_a        <= 1'b0;
      pend_t        <= 1'b0;
      beeps         <= '0;
      ms_cnt        <= '0;
      done_evt      <= 1'b0;
      Tone_Answer   <= 1'b0;
      Tone_TimeOver <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      state         <= state_n;
      pat           <= pat_n;
      pend_a        <= pend_a_n;
      pend_t        <= pend_t_n;
      beeps         <= beeps_n;
      ms_cnt        <= enter ? '0 : ms_cnt + MW'(tick && state != S_IDLE);
      done_evt      <= done_n;
      Tone_Answer   <= tone_a_n;
      Tone_TimeOver <= tone_t_n;
      Busy          <= busy_n;
      Done          <= done_o_n;
    end

  always_comb begin
    state_n  = state;
    pat_n    = pat;
    beeps_n  = beeps;
    done_n   = 1'b0;
    pend_t_n = (pend_t && !load_t) || Req_TimeOver;
    pend_a_n = (pend_a && !load_a) || Req_Answer;
    if (Clear) begin
      state_n  = S_IDLE;
      pend_t_n = 1'b0;
      pend_a_n = 1'b0;
      beeps_n  = '0;
    end else if (load_t || load_a) begin
      state_n = S_ON;
      pat_n   = load_t ? P_TO : P_ANS;
      beeps_n = load_t ? 4'(TO_BEEPS - 1) : 4'(ANS_BEEPS - 1);
    end else if (ms_end && state == S_ON) begin
      state_n = S_OFF;
    end else if (ms_end && state == S_OFF) begin
      state_n = beeps != '0 ? S_ON : S_IDLE;
      beeps_n = beeps != '0 ? beeps - 4'd1 : beeps;
      done_n  = beeps == '0;
    end
  end

  // outputs trail the FSM by one edge, except Clear which silences them at once
  always_comb begin
    tone_a_n = !Clear && state == S_ON && pat == P_ANS;
    tone_t_n = !Clear && state == S_ON && pat == P_TO;
    busy_n   = !Clear && state != S_IDLE;
    done_o_n = !Clear && done_evt;
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb_buzzer_sequencer: directed scenarios plus random requests checked against a timeline model of beep patterns.
module tb_buzzer_sequencer;

  localparam int TD  = 4;
  localparam int AON = 3;
  localparam int ANB = 1;
  localparam int TON = 2;
  localparam int TNB = 3;
  localparam int OFF = 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Req_Answer = 1'b0;
  logic Req_TimeOver = 1'b0;
  logic Clear = 1'b0;
  logic Tone_Answer, Tone_TimeOver, Busy, Done;

  always #5 CLK = ~CLK;

  buzzer_sequencer #(
    .TICK_DIV (TD),
    .ANS_BEEPS(ANB),
    .ANS_ON_MS(AON),
    .TO_BEEPS (TNB),
    .TO_ON_MS (TON),
    .OFF_MS   (OFF)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Req_Answer   (Req_Answer),
    .Req_TimeOver (Req_TimeOver),
    .Clear        (Clear),
    .Tone_Answer  (Tone_Answer),
    .Tone_TimeOver(Tone_TimeOver),
    .Busy         (Busy),
    .Done         (Done)
  );

  int checks = 0;
  int errors = 0;

  // model: which pattern plays (0 none, 1 answer, 2 time-over) and cycles since it started
  int m_play, m_t;
  bit m_pa, m_pt, m_fin;
  bit e_ta, e_tt, e_busy, e_done;
  int ta_cnt, tt_cnt, busy_cnt, done_cnt;

  function automatic int nbeeps(int p);
    return p == 2 ? TNB : ANB;
  endfunction

  function automatic int on_len(int p);
    return (p == 2 ? TON : AON) * TD;
  endfunction

  function automatic int period(int p);
    return on_len(p) + OFF * TD;
  endfunction

  task automatic chk(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_t = 0; m_pa = 0; m_pt = 0; m_fin = 0;
    e_ta = 0; e_tt = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic model_edge(bit ra, bit rt, bit cl);
    if (cl) begin
      model_reset();
      return;
    end
    e_ta   = m_play == 1 && (m_t % period(1)) < on_len(1);
    e_tt   = m_play == 2 && (m_t % period(2)) < on_len(2);
    e_busy = m_play != 0;
    e_done = m_fin;
    m_fin  = 0;
    if (m_pt && m_play != 2) begin
      m_play = 2; m_t = 0; m_pt = 0;
    end else if (m_pa && m_play == 0) begin
      m_play = 1; m_t = 0; m_pa = 0;
    end else if (m_play != 0) begin
      m_t++;
      if (m_t == nbeeps(m_play) * period(m_play)) begin
        m_play = 0;
        m_fin  = 1;
      end
    end
    m_pt = m_pt | rt;
    m_pa = m_pa | ra;
  endtask

  task automatic clear_stats();
    ta_cnt = 0; tt_cnt = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic step(bit ra, bit rt, bit cl);
    Req_Answer = ra; Req_TimeOver = rt; Clear = cl;
    @(posedge CLK);
    model_edge(ra, rt, cl);
    #1;
    Req_Answer = 0; Req_TimeOver = 0; Clear = 0;
    chk("tone_answer", Tone_Answer, e_ta);
    chk("tone_timeover", Tone_TimeOver, e_tt);
    chk("busy", Busy, e_busy);
    chk("done", Done, e_done);
    chk("tone_exclusive", Tone_Answer & Tone_TimeOver, 1'b0);
    ta_cnt   += int'(Tone_Answer);
    tt_cnt   += int'(Tone_TimeOver);
    busy_cnt += int'(Busy);
    done_cnt += int'(Done);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    model_reset();
    clear_stats();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tone_answer", Tone_Answer, 1'b0);
    chk("rst_tone_timeover", Tone_TimeOver, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    RST = 0;
    idle(3);

    clear_stats();
    step(1, 0, 0);
    idle(25);
    chk_int("answer_tone_cycles", ta_cnt, AON * TD);
    chk_int("answer_busy_cycles", busy_cnt, (AON + OFF) * TD);
    chk_int("answer_done_count", done_cnt, 1);

    clear_stats();
    step(0, 1, 0);
    idle(40);
    chk_int("timeover_tone_cycles", tt_cnt, TNB * TON * TD);
    chk_int("timeover_done_count", done_cnt, 1);

    clear_stats();
    step(1, 0, 0);
    idle(4);
    step(0, 1, 0);
    idle(45);
    chk_int("preempt_done_count", done_cnt, 1);
    chk_int("preempt_timeover_cycles", tt_cnt, TNB * TON * TD);

    clear_stats();
    step(1, 1, 0);
    idle(60);
    chk_int("both_done_count", done_cnt, 2);
    chk_int("both_answer_cycles", ta_cnt, AON * TD);
    chk_int("both_timeover_cycles", tt_cnt, TNB * TON * TD);

    step(1, 0, 0);
    idle(5);
    step(1, 0, 1);
    clear_stats();
    idle(20);
    chk_int("clear_no_replay", ta_cnt + busy_cnt + done_cnt, 0);

    step(1, 0, 0);
    idle(13);
    chk("pre_reset_busy", Busy, 1'b1);
    #2 RST = 1;
    #1;
    model_reset();
    chk("async_rst_tone_answer", Tone_Answer, 1'b0);
    chk("async_rst_busy", Busy, 1'b0);
    chk("async_rst_done", Done, 1'b0);
    #1 RST = 0;
    idle(2);
    clear_stats();
    step(1, 0, 0);
    idle(20);
    chk_int("after_reset_tone_cycles", ta_cnt, AON * TD);
    chk_int("after_reset_done_count", done_cnt, 1);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(39) == 0, $urandom_range(59) == 0, $urandom_range(149) == 0);
    idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
